// File: rtl/avr_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default entry key
// and a small sizing helper.
package avr_pkg;

    typedef enum logic [2:0] {
        StHunt0,
        StHunt1,
        StHunt2,
        StLoad,
        StExit
    } loader_state_e;

    localparam logic [7:0] SYNC0_DEF = 8'hA9;
    localparam logic [7:0] SYNC1_DEF = 8'h44;
    localparam logic [7:0] SYNC2_DEF = 8'h45;

    // Counter width for n states, never below one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_sync_hunt.sv
// Entry-key hunter: watches the byte stream for SYNC0, SYNC1, SYNC2 and flags the
// cycle in which the final key byte arrives.
module prog_sync_hunt
    import avr_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEF,
    parameter logic [7:0] SYNC1 = SYNC1_DEF,
    parameter logic [7:0] SYNC2 = SYNC2_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_key_found
);

    loader_state_e r_state;

    // Decoded rather than registered so the loader enters LOAD on the same edge.
    assign o_key_found = i_enable && i_rx_valid && (r_state == StHunt2) &&
                         (i_rx_data == SYNC2);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StHunt0;
        end else if (!i_enable) begin
            r_state <= StHunt0;
        end else if (i_rx_valid) begin
            case (r_state)
                StHunt0: begin
                    if (i_rx_data == SYNC0) r_state <= StHunt1;
                end
                StHunt1: begin
                    if (i_rx_data == SYNC1)      r_state <= StHunt2;
                    else if (i_rx_data == SYNC0) r_state <= StHunt1;
                    else                         r_state <= StHunt0;
                end
                StHunt2: begin
                    if (i_rx_data == SYNC2)      r_state <= StHunt0;
                    else if (i_rx_data == SYNC0) r_state <= StHunt1;
                    else                         r_state <= StHunt0;
                end
                default: r_state <= StHunt0;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: after the entry key, packs payload bytes into flash words,
// writes them sequentially, keeps a byte checksum and leaves on an idle timeout.
module prog_loader
    import avr_pkg::*;
#(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned WORD_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  SYNC0          = SYNC0_DEF,
    parameter logic [7:0]  SYNC1          = SYNC1_DEF,
    parameter logic [7:0]  SYNC2          = SYNC2_DEF,
    parameter bit          MSB_FIRST      = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_prog_mode,
    output logic                    o_core_hold,
    output logic [ADDR_W-1:0]       o_flash_addr,
    output logic [8*WORD_BYTES-1:0] o_flash_data,
    output logic                    o_flash_we,
    output logic                    o_done,
    output logic                    o_done_err,
    output logic [7:0]              o_chk_sum
);

    localparam int unsigned LW = cnt_bits(WORD_BYTES);
    localparam int unsigned TW = cnt_bits(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam logic [LW-1:0] LANE_LAST = LW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES);

    loader_state_e     r_state;
    logic [LW-1:0]     r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [DW-1:0]     r_word;
    logic [TW-1:0]     r_timeout;
    logic              r_ovf;
    logic              r_prog_mode;
    logic [ADDR_W-1:0] r_flash_addr;
    logic [DW-1:0]     r_flash_data;
    logic              r_flash_we;
    logic              r_done;
    logic              r_done_err;
    logic [7:0]        r_chk_sum;

    logic          w_key_found;
    logic [LW-1:0] w_sel;
    logic [DW-1:0] w_word;

    prog_sync_hunt #(
        .SYNC0 (SYNC0),
        .SYNC1 (SYNC1),
        .SYNC2 (SYNC2)
    ) u_hunt (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_enable    (r_state == StHunt0),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_key_found (w_key_found)
    );

    assign w_sel = MSB_FIRST ? (LANE_LAST - r_lane) : r_lane;

    // Current partial word with the incoming byte merged into its lane.
    always_comb begin
        int unsigned w_bit;
        w_bit  = 32'(w_sel) * 8;
        w_word = r_word;
        w_word[w_bit +: 8] = i_rx_data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StHunt0;
            r_lane       <= '0;
            r_addr       <= '0;
            r_word       <= '0;
            r_timeout    <= '0;
            r_ovf        <= 1'b0;
            r_prog_mode  <= 1'b0;
            r_flash_addr <= '0;
            r_flash_data <= '0;
            r_flash_we   <= 1'b0;
            r_done       <= 1'b0;
            r_done_err   <= 1'b0;
            r_chk_sum    <= '0;
        end else begin
            r_flash_we <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                StLoad: begin
                    if (i_rx_valid) begin
                        r_word    <= w_word;
                        r_chk_sum <= r_chk_sum + i_rx_data;
                        r_timeout <= TO_LOAD;
                        if (r_lane == LANE_LAST) begin
                            r_lane <= '0;
                            if (!r_ovf) begin
                                r_flash_we   <= 1'b1;
                                r_flash_addr <= r_addr;
                                r_flash_data <= w_word;
                                if (r_addr == '1) r_ovf  <= 1'b1;
                                else              r_addr <= r_addr + ADDR_W'(1);
                            end
                        end else begin
                            r_lane <= r_lane + LW'(1);
                        end
                    end else if (r_timeout <= TW'(1)) begin
                        r_timeout   <= '0;
                        r_state     <= StExit;
                        r_prog_mode <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_err  <= (r_lane != '0) | r_ovf;
                    end else begin
                        r_timeout <= r_timeout - TW'(1);
                    end
                end
                StExit: begin
                    // Any partial word is dropped here.
                    r_state <= StHunt0;
                    r_lane  <= '0;
                    r_word  <= '0;
                end
                default: begin
                    if (w_key_found) begin
                        r_state     <= StLoad;
                        r_prog_mode <= 1'b1;
                        r_lane      <= '0;
                        r_addr      <= '0;
                        r_word      <= '0;
                        r_ovf       <= 1'b0;
                        r_chk_sum   <= '0;
                        r_timeout   <= TO_LOAD;
                    end
                end
            endcase
        end
    end

    assign o_prog_mode  = r_prog_mode;
    assign o_core_hold  = r_prog_mode;
    assign o_flash_addr = r_flash_addr;
    assign o_flash_data = r_flash_data;
    assign o_flash_we   = r_flash_we;
    assign o_done       = r_done;
    assign o_done_err   = r_done_err;
    assign o_chk_sum    = r_chk_sum;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a 2-byte/4-word instance for key, assembly, timeout,
// overflow and reset cases, and a 4-byte LSB-first instance for byte order.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;

    always #5 clk = ~clk;

    logic        a_mode, a_hold, a_we, a_done, a_err;
    logic [1:0]  a_addr;
    logic [15:0] a_data;
    logic [7:0]  a_chk;

    logic        b_mode, b_hold, b_we, b_done, b_err;
    logic [13:0] b_addr;
    logic [31:0] b_data;
    logic [7:0]  b_chk;

    prog_loader #(
        .ADDR_W         (2),
        .WORD_BYTES     (2),
        .TIMEOUT_CYCLES (100),
        .MSB_FIRST      (1'b1)
    ) dut_a (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_prog_mode  (a_mode),
        .o_core_hold  (a_hold),
        .o_flash_addr (a_addr),
        .o_flash_data (a_data),
        .o_flash_we   (a_we),
        .o_done       (a_done),
        .o_done_err   (a_err),
        .o_chk_sum    (a_chk)
    );

    prog_loader #(
        .ADDR_W         (14),
        .WORD_BYTES     (4),
        .TIMEOUT_CYCLES (100),
        .MSB_FIRST      (1'b0)
    ) dut_b (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_prog_mode  (b_mode),
        .o_core_hold  (b_hold),
        .o_flash_addr (b_addr),
        .o_flash_data (b_data),
        .o_flash_we   (b_we),
        .o_done       (b_done),
        .o_done_err   (b_err),
        .o_chk_sum    (b_chk)
    );

    // Write/done log for dut_a, sampled mid-cycle.
    logic [1:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (a_we) begin
            wr_addr_q.push_back(a_addr);
            wr_data_q.push_back(a_data);
        end
        if (a_done) done_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_key();
        send(8'hA9);
        send(8'h44);
        send(8'h45);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Bounded wait for a_done; leaves the bench inside the done cycle when seen.
    task automatic wait_done(input int limit, output int k, output bit seen);
        k    = 0;
        seen = 1'b0;
        while (k < limit && !seen) begin
            tick();
            k++;
            if (a_done) seen = 1'b1;
        end
    endtask

    typedef struct {
        logic [47:0] bytes;  // first byte in [47:40]
        int          n;
        logic        exp_mode;
    } kvec_t;

    kvec_t vecs[7];

    initial begin
        int          k;
        bit          seen;
        int          wbase;
        int          dbase;
        logic [47:0] tmp;

        vecs[0] = '{48'hA94445_000000, 3, 1'b1};
        vecs[1] = '{48'hA9A94445_0000, 4, 1'b1};
        vecs[2] = '{48'hA94400_000000, 3, 1'b0};
        vecs[3] = '{48'hA944A94445_00, 5, 1'b1};
        vecs[4] = '{48'h4445A9_000000, 3, 1'b0};
        vecs[5] = '{48'hA9454445_0000, 4, 1'b0};
        vecs[6] = '{48'hA9A9A94445_00, 5, 1'b1};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        chk("rst_mode",  64'(a_mode), 64'(0));
        chk("rst_hold",  64'(a_hold), 64'(0));
        chk("rst_we",    64'(a_we),   64'(0));
        chk("rst_done",  64'(a_done), 64'(0));
        chk("rst_err",   64'(a_err),  64'(0));
        chk("rst_chk",   64'(a_chk),  64'(0));
        chk("rst_addr",  64'(a_addr), 64'(0));
        chk("rst_data",  64'(a_data), 64'(0));
        chk("rst_b_mode", 64'(b_mode), 64'(0));
        chk("rst_b_data", 64'(b_data), 64'(0));

        // Key hunt table.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            wbase = wr_addr_q.size();
            tmp   = vecs[v].bytes;
            for (int i = 0; i < vecs[v].n; i++) send(tmp[47-8*i -: 8]);
            chk($sformatf("key%0d_mode", v), 64'(a_mode), 64'(vecs[v].exp_mode));
            chk($sformatf("key%0d_hold", v), 64'(a_hold), 64'(vecs[v].exp_mode));
            chk($sformatf("key%0d_chk", v),  64'(a_chk),  64'(0));
            chk($sformatf("key%0d_nowr", v), 64'(wr_addr_q.size() - wbase), 64'(0));
        end

        // Word assembly and clean exit.
        do_reset();
        wbase = wr_addr_q.size();
        send_key();
        send(8'h12);
        chk("asm_we_mid", 64'(a_we), 64'(0));
        send(8'h34);
        chk("asm_we0",   64'(a_we),   64'(1));
        chk("asm_addr0", 64'(a_addr), 64'(0));
        chk("asm_data0", 64'(a_data), 64'(16'h1234));
        send(8'h56);
        chk("asm_we_pulse", 64'(a_we), 64'(0));
        send(8'h78);
        chk("asm_we1",   64'(a_we),   64'(1));
        chk("asm_addr1", 64'(a_addr), 64'(1));
        chk("asm_data1", 64'(a_data), 64'(16'h5678));
        chk("asm_chk",   64'(a_chk),  64'(8'h14));
        wait_done(300, k, seen);
        chk("asm_done_seen", 64'(seen), 64'(1));
        chk("asm_idle_cnt",  64'(k),    64'(100));
        chk("asm_done_err",  64'(a_err), 64'(0));
        chk("asm_mode_exit", 64'(a_mode), 64'(0));
        chk("asm_hold_exit", 64'(a_hold), 64'(0));
        tick();
        chk("asm_done_once", 64'(a_done), 64'(0));
        chk("asm_chk_hold",  64'(a_chk),  64'(8'h14));
        chk("asm_nwr",       64'(wr_addr_q.size() - wbase), 64'(2));

        // Timeout with a partial word pending.
        do_reset();
        wbase = wr_addr_q.size();
        send_key();
        send(8'h12);
        send(8'h34);
        send(8'hAB);
        wait_done(300, k, seen);
        chk("to_done_seen", 64'(seen),  64'(1));
        chk("to_idle_cnt",  64'(k),     64'(100));
        chk("to_done_err",  64'(a_err), 64'(1));
        chk("to_chk",       64'(a_chk), 64'(8'hF1));
        chk("to_nwr",       64'(wr_addr_q.size() - wbase), 64'(1));
        if (wr_data_q.size() > wbase) chk("to_wr_data", 64'(wr_data_q[wbase]), 64'(16'h1234));
        tick();
        send(8'h12);
        send(8'h34);
        chk("to_rekey_mode", 64'(a_mode), 64'(0));
        chk("to_rekey_nwr",  64'(wr_addr_q.size() - wbase), 64'(1));

        // Byte arriving on the cycle the counter would hit zero.
        do_reset();
        send_key();
        repeat (99) tick();
        send(8'h55);
        chk("edge_mode", 64'(a_mode), 64'(1));
        chk("edge_done", 64'(a_done), 64'(0));
        wait_done(300, k, seen);
        chk("edge_idle_cnt", 64'(k),     64'(100));
        chk("edge_err",      64'(a_err), 64'(1));
        chk("edge_chk",      64'(a_chk), 64'(8'h55));

        // Address overflow: five words into a four-word space.
        do_reset();
        wbase = wr_addr_q.size();
        send_key();
        for (int i = 1; i <= 10; i++) send(8'(i));
        wait_done(300, k, seen);
        chk("ovf_done_seen", 64'(seen),  64'(1));
        chk("ovf_done_err",  64'(a_err), 64'(1));
        chk("ovf_chk",       64'(a_chk), 64'(8'h37));
        chk("ovf_nwr",       64'(wr_addr_q.size() - wbase), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (wr_addr_q.size() > wbase + i) begin
                chk($sformatf("ovf_addr%0d", i), 64'(wr_addr_q[wbase+i]), 64'(i));
                chk($sformatf("ovf_data%0d", i), 64'(wr_data_q[wbase+i]),
                    64'({8'(2*i+1), 8'(2*i+2)}));
            end
        end

        // Reset in the middle of a word.
        do_reset();
        wbase = wr_addr_q.size();
        dbase = done_cnt;
        send_key();
        send(8'h12);
        chk("abort_pre_chk", 64'(a_chk), 64'(8'h12));
        rst_n = 1'b0;
        #1;
        chk("abort_mode", 64'(a_mode), 64'(0));
        chk("abort_hold", 64'(a_hold), 64'(0));
        chk("abort_chk",  64'(a_chk),  64'(0));
        chk("abort_we",   64'(a_we),   64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h34);
        chk("abort_out_mode", 64'(a_mode), 64'(0));
        chk("abort_nwr",  64'(wr_addr_q.size() - wbase), 64'(0));
        chk("abort_ndone", 64'(done_cnt - dbase), 64'(0));
        send_key();
        chk("abort_rekey", 64'(a_mode), 64'(1));
        send(8'h56);
        send(8'h78);
        chk("abort_wr_we",   64'(a_we),   64'(1));
        chk("abort_wr_addr", 64'(a_addr), 64'(0));
        chk("abort_wr_data", 64'(a_data), 64'(16'h5678));

        // LSB-first, four bytes per word.
        do_reset();
        send_key();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("ord_we_mid", 64'(b_we), 64'(0));
        send(8'h04);
        chk("ord_we",   64'(b_we),   64'(1));
        chk("ord_addr", 64'(b_addr), 64'(0));
        chk("ord_data", 64'(b_data), 64'(32'h04030201));
        chk("ord_chk",  64'(b_chk),  64'(8'h0A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
